// File: rtl/seg7_count_display_if.sv
// Count bus and display pin bundle for seg7_count_display.
// slave  : the display block (consumes i_count, drives the display pins).
// master : the producer/observer side (drives i_count, watches the pins).
// o_dbg_state exposes the converter FSM state (0 = IDLE, 1 = SHIFT).
interface seg7_count_display_if;
  logic [13:0] i_count;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_busy;
  logic        o_dbg_state;

  modport master (
    output i_count,
    input  o_seg, o_dp, o_an, o_busy, o_dbg_state
  );

  modport slave (
    input  i_count,
    output o_seg, o_dp, o_an, o_busy, o_dbg_state
  );
endinterface

// File: rtl/seg7_count_display.sv
// seg7_count_display: binary count -> 4 BCD digits (sequential double-dabble)
// -> multiplexed common-anode 7-segment display, all outputs active-low.
// Optional feature macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
//
// Handshake: there is no valid/ready pair; i_count is a level. The converter
// samples it only in IDLE and starts a conversion whenever it differs from
// the last converted value. o_busy is high for exactly the 14 SHIFT cycles;
// changes of i_count while busy are not queued, IDLE re-compares afterwards.
module seg7_count_display #(
  parameter int CLK_DIV   = 50000,
  parameter int MAX_VALUE = 9999
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  seg7_count_display_if.slave  bus
);

  localparam int            PW       = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  // Nibble value used in the digit register to mean "dash".
  localparam logic [3:0]    DASH_NIB = 4'hA;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [13:0]   r_bin;
  logic [13:0]   r_last;
  logic [15:0]   r_bcd;
  logic [3:0]    r_cnt;
  logic [15:0]   r_digits;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_start;
  logic          w_last_shift;
  logic          w_ovf;
  logic [15:0]   w_adj;
  logic [15:0]   w_bcd_shift;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic [31:0]   w_last_ext;

  assign w_start      = (r_state == S_IDLE) && (bus.i_count != r_last);
  assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == 4'd13);
  assign w_last_ext   = {18'd0, r_last};
  assign w_ovf        = w_last_ext > 32'(MAX_VALUE);

  // Converter state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Converter next-state: IDLE starts on a new value, SHIFT runs 14 cycles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)      w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last_shift) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, then one left shift of {bcd,bin}.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_bcd_shift = {w_adj[14:0], r_bin[13]};
  end

  // Conversion datapath; the digit register only loads on the final shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bin    <= '0;
      r_last   <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
    end else if (w_start) begin
      r_bin  <= bus.i_count;
      r_last <= bus.i_count;
      r_bcd  <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_bcd <= w_bcd_shift;
      r_bin <= {r_bin[12:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (w_last_shift) r_digits <= w_ovf ? {4{DASH_NIB}} : w_bcd_shift;
    end
  end

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    w_digit = r_digits[4*r_idx +: 4];
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      DASH_NIB: w_seg = 7'b0111111;
      default: w_seg = 7'b1111111;
    endcase
`ifdef SEG7_LZ_BLANK_EN
    // Digit k blanks when it and every higher digit are zero; dash nibbles
    // are non-zero so the overflow pattern is never blanked.
    if (r_idx == 2'd3 && r_digits[15:12] == 4'd0)
      w_seg = 7'b1111111;
    if (r_idx == 2'd2 && r_digits[15:8] == 8'd0)
      w_seg = 7'b1111111;
    if (r_idx == 2'd1 && r_digits[15:4] == 12'd0)
      w_seg = 7'b1111111;
`endif
  end

  // Scan prescaler/index and registered anode/segment drivers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= 7'h7F;
      r_an  <= 4'hF;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
    end
  end

  assign bus.o_seg       = r_seg;
  assign bus.o_an        = r_an;
  assign bus.o_dp        = 1'b1;
  assign bus.o_busy      = (r_state == S_SHIFT);
  assign bus.o_dbg_state = r_state;

endmodule
